// File: rtl/conv_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module    : conv_pkg
// Purpose   : Types and constants shared by the convolution frame streamer:
//             FSM state encoding, per-beat row-edge codes, lane width.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int PIX_W = 8;

  localparam logic [1:0] ROWEND_FIRST = 2'b10;
  localparam logic [1:0] ROWEND_LAST  = 2'b01;
  localparam logic [1:0] ROWEND_MID   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    FIN    = 3'd4
  } state_t;

  // A row of a single beat is both first and last, so neither edge bit is set.
  function automatic logic [1:0] rowend_code(input logic first, input logic last);
    if (first && last) return 2'b00;
    else if (first)    return ROWEND_FIRST;
    else if (last)     return ROWEND_LAST;
    else               return ROWEND_MID;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module    : conv_frame_streamer_if
// Purpose   : Bundles the pixel-memory read port and the convolver-facing
//             beat stream of the frame streamer.
// Ports     : mem_rd/mem_addr (to memory), mem_data (from memory),
//             data_out/valid/rowend/clrbuffer (to convolver),
//             stall (from convolver).
//             master = streamer side, slave = memory/convolver side.
// Revision  : 1.0 - initial release
// ============================================================================
interface conv_frame_streamer_if #(
  parameter int NO_PARALLEL_UNITS = 4,
  parameter int ADDR_W            = 18,
  parameter int ker               = 3
);
  logic                                         mem_rd;
  logic [ADDR_W-1:0]                            mem_addr;
  logic [NO_PARALLEL_UNITS*conv_pkg::PIX_W-1:0] mem_data;
  logic [NO_PARALLEL_UNITS*conv_pkg::PIX_W-1:0] data_out;
  logic                                         valid;
  logic [ker-2:0]                               rowend;
  logic                                         clrbuffer;
  logic                                         stall;

  modport master (
    output mem_rd, mem_addr, data_out, valid, rowend, clrbuffer,
    input  mem_data, stall
  );

  modport slave (
    input  mem_rd, mem_addr, data_out, valid, rowend, clrbuffer,
    output mem_data, stall
  );
endinterface
`default_nettype wire

// File: rtl/conv_frame_streamer_skid2.sv
`default_nettype none
// ============================================================================
// Module    : stream_skid2
// Purpose   : Two-entry beat buffer between the memory return path and the
//             convolver. Entry 0 is the registered output beat; entry 1
//             absorbs the word still in flight when stall rises.
// Ports     : clk, res       - clock, synchronous active-high reset
//             in_valid/in_data - word arriving this cycle
//             stall          - downstream hold
//             out_valid/out_data - current beat (held while stalled)
//             room           - a request issued now will find a free slot
// Revision  : 1.0 - initial release
// ============================================================================
module stream_skid2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         res,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         stall,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         room
);
  logic [W-1:0] ent0, ent1;
  logic [1:0]   count;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = ent0;
  assign pop       = out_valid && !stall;

  // Occupancy after this cycle (arrival in, accepted beat out) must leave a
  // slot for the word a request issued now returns next cycle.
  assign room = ({1'b0, count} + {2'b00, in_valid}) < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk) begin
    if (res) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_data;
          else               ent1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_data;
          end else begin
            ent0 <= ent1;
            ent1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/conv_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module    : conv_frame_streamer
// Purpose   : On start, reads one grayscale frame row-major from a
//             word-addressed pixel memory and streams it to the 3x3
//             convolver as NO_PARALLEL_UNITS-lane beats with row-edge flags,
//             a buffer-clear pulse and stall-safe valid handshake.
// Ports     : clk, res  - clock, synchronous active-high reset
//             start     - frame request (idle only)
//             busy      - frame in progress
//             done      - one-cycle pulse after the final beat is accepted
//             bus       - memory read port + convolver beat stream (master)
// Config    : CONV_STREAM_FLUSH_EN - append ker/2 zero rows after the frame
//             so the convolver line buffers drain the last image row.
// Revision  : 1.0 - initial release
// ============================================================================
module conv_frame_streamer
  import conv_pkg::*;
#(
  parameter int IM_LEN            = 520,
  parameter int IM_ROWS           = 520,
  parameter int ker               = 3,
  parameter int NO_PARALLEL_UNITS = 4,
  parameter int ADDR_W            = 18
) (
  input  logic clk,
  input  logic res,
  input  logic start,
  output logic busy,
  output logic done,
  conv_frame_streamer_if.master bus
);
  localparam int BPR = IM_LEN / NO_PARALLEL_UNITS;
  localparam int DW  = NO_PARALLEL_UNITS * PIX_W;
  localparam int RW  = ker - 1;
`ifdef CONV_STREAM_FLUSH_EN
  localparam int FLUSH_ROWS = ker / 2;
`else
  localparam int FLUSH_ROWS = 0;
`endif
  localparam int COL_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int ROW_W = $clog2(IM_ROWS + FLUSH_ROWS + 1);
  localparam logic [COL_W-1:0] LAST_COL       = COL_W'(BPR - 1);
  localparam logic [ROW_W-1:0] LAST_FRAME_ROW = ROW_W'(IM_ROWS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW       = ROW_W'(IM_ROWS - 1 + FLUSH_ROWS);

  state_t            state, state_nx;
  logic              room, issue, last_col, last_frame_beat, last_flush_beat;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              pend_valid, pend_zero;
  logic [RW-1:0]     pend_rowend, issue_rowend;
  logic [DW-1:0]     pend_pix;
  logic [DW+RW-1:0]  skid_out;

  assign last_col        = (col == LAST_COL);
  assign last_frame_beat = last_col && (row == LAST_FRAME_ROW);
  assign last_flush_beat = last_col && (row == LAST_ROW);
  assign issue_rowend    = RW'(rowend_code(col == '0, last_col));
  assign busy            = (state != IDLE);
  assign bus.mem_addr    = addr;

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    issue         = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.clrbuffer = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: if (start) state_nx = CLEAR;
      CLEAR: begin
        bus.clrbuffer = 1'b1;
        state_nx      = STREAM;
      end
      STREAM: begin
        issue      = room;
        bus.mem_rd = room;
        if (room && last_frame_beat) begin
`ifdef CONV_STREAM_FLUSH_EN
          state_nx = (FLUSH_ROWS > 0) ? FLUSH : FIN;
`else
          state_nx = FIN;
`endif
        end
      end
`ifdef CONV_STREAM_FLUSH_EN
      FLUSH: begin
        issue = room;
        if (room && last_flush_beat) state_nx = FIN;
      end
`endif
      FIN: begin
        // Nothing in flight and nothing buffered means the last beat was taken.
        if (!pend_valid && !bus.valid) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat position counters and the one-cycle in-flight stage. Flush beats
  // travel through the same stage as reads so ordering is preserved.
  always_ff @(posedge clk) begin
    if (res) begin
      col         <= '0;
      row         <= '0;
      addr        <= '0;
      pend_valid  <= 1'b0;
      pend_zero   <= 1'b0;
      pend_rowend <= '0;
    end else begin
      pend_valid  <= issue;
      pend_zero   <= (state != STREAM);
      pend_rowend <= issue_rowend;
      if (state == CLEAR) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (issue) begin
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        // Address parks on the last word so it never leaves the frame.
        if (bus.mem_rd && !last_frame_beat) addr <= addr + 1'b1;
      end
    end
  end

  assign pend_pix = pend_zero ? '0 : bus.mem_data;

  stream_skid2 #(.W(DW + RW)) u_skid (
    .clk       (clk),
    .res       (res),
    .in_valid  (pend_valid),
    .in_data   ({pend_pix, pend_rowend}),
    .stall     (bus.stall),
    .out_valid (bus.valid),
    .out_data  (skid_out),
    .room      (room)
  );

  assign bus.data_out = skid_out[DW+RW-1:RW];
  assign bus.rowend   = skid_out[RW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module    : tb_conv_frame_streamer
// Purpose   : Directed self-checking bench for conv_frame_streamer with an
//             8x3 frame, 4 lanes (2 beats per row); memory word n holds
//             {4{8'(n)}}.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_conv_frame_streamer;
`ifdef CONV_STREAM_FLUSH_EN
  localparam int NB = 8;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME_BEATS = 6;

  logic clk = 1'b0;
  logic res, start, busy, done;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  conv_frame_streamer_if #(.NO_PARALLEL_UNITS(4), .ADDR_W(18), .ker(3)) bus ();

  conv_frame_streamer #(
    .IM_LEN(8), .IM_ROWS(3), .ker(3), .NO_PARALLEL_UNITS(4), .ADDR_W(18)
  ) dut (
    .clk(clk), .res(res), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  // Pixel memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= {4{bus.mem_addr[7:0]}};
  end

  function automatic logic [31:0] exp_data(input int n);
    logic [7:0] b;
    b = n[7:0];
    if (n >= FRAME_BEATS) return 32'h0;
    return {4{b}};
  endfunction

  function automatic logic [1:0] exp_rowend(input int n);
    return (n % 2 == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1; start = 1'b0; bus.stall = 1'b0;
    step(); step();
    res = 1'b0;
    checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.data_out, bus.valid, bus.rowend, bus.clrbuffer, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%b addr=%h data=%h valid=%b rowend=%b clr=%b busy=%b done=%b expected all zero",
               bus.mem_rd, bus.mem_addr, bus.data_out, bus.valid, bus.rowend, bus.clrbuffer, busy, done);
    end
  endtask

  task automatic test_basic_frame();
    start = 1'b1; step(); start = 1'b0;                // T+1
    checks++;
    if (bus.clrbuffer !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_clr_t1: got clr=%b busy=%b expected 1 1", bus.clrbuffer, busy);
    end
    step();                                            // T+2
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 18'd0 || bus.clrbuffer !== 1'b0) begin
      failures++;
      $display("FAIL basic_first_rd: got rd=%b addr=%0d clr=%b expected 1 0 0", bus.mem_rd, bus.mem_addr, bus.clrbuffer);
    end
    step();                                            // T+3
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_t3_valid: got %b expected 0", bus.valid);
    end
    for (int i = 0; i < NB; i++) begin
      step();                                          // T+4+i
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== exp_data(i) || bus.rowend !== exp_rowend(i) || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_beat%0d: got valid=%b data=%h rowend=%b done=%b expected 1 %h %b 0",
                 i, bus.valid, bus.data_out, bus.rowend, done, exp_data(i), exp_rowend(i));
      end
    end
    step();                                            // T+4+NB
    checks++;
    if (done !== 1'b1 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: got done=%b valid=%b expected 1 0", done, bus.valid);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_after: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_stall_hold();
    start = 1'b1; step(); start = 1'b0;                // T+1
    repeat (5) step();                                 // T+6
    checks++;
    if (bus.valid !== 1'b1 || bus.data_out !== exp_data(2)) begin
      failures++;
      $display("FAIL stall_pre: got valid=%b data=%h expected 1 %h", bus.valid, bus.data_out, exp_data(2));
    end
    bus.stall = 1'b1;                                  // stalled T+6..T+8
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== exp_data(2) || bus.rowend !== 2'b10 || bus.mem_addr > 18'd5) begin
        failures++;
        $display("FAIL stall_hold%0d: got valid=%b data=%h rowend=%b addr=%0d expected 1 %h 10 <=5",
                 k, bus.valid, bus.data_out, bus.rowend, bus.mem_addr, exp_data(2));
      end
    end
    bus.stall = 1'b0;                                  // beat 2 accepted at T+9
    for (int i = 3; i < NB; i++) begin
      step();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== exp_data(i) || bus.rowend !== exp_rowend(i) || bus.mem_addr > 18'd5) begin
        failures++;
        $display("FAIL stall_resume_beat%0d: got valid=%b data=%h rowend=%b addr=%0d expected 1 %h %b <=5",
                 i, bus.valid, bus.data_out, bus.rowend, bus.mem_addr, exp_data(i), exp_rowend(i));
      end
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL stall_done: got %b expected 1", done);
    end
    step();
  endtask

  task automatic test_random_stall();
    int   acc = 0;
    bit   seen_done = 1'b0;
    logic s;
    start = 1'b1; step(); start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (done) seen_done = 1'b1;
      s = 1'($urandom_range(0, 1));
      bus.stall = s;
      if (bus.valid && !s) begin
        checks++;
        if (bus.data_out !== exp_data(acc) || bus.rowend !== exp_rowend(acc)) begin
          failures++;
          $display("FAIL rand_beat%0d: got data=%h rowend=%b expected %h %b",
                   acc, bus.data_out, bus.rowend, exp_data(acc), exp_rowend(acc));
        end
        acc++;
      end
      step();
    end
    bus.stall = 1'b0;
    checks++;
    if (acc != NB || !seen_done) begin
      failures++;
      $display("FAIL rand_count: got beats=%0d done_seen=%0d expected %0d 1", acc, seen_done, NB);
    end
    step();
  endtask

  task automatic test_reset_mid_stream();
    int ndone = 0;
    start = 1'b1; step(); start = 1'b0;                // T+1
    repeat (4) step();                                 // T+5, streaming
    res = 1'b1;
    step();
    res = 1'b0;
    checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.data_out, bus.valid, bus.rowend, bus.clrbuffer, busy, done} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got rd=%b addr=%h data=%h valid=%b rowend=%b clr=%b busy=%b done=%b expected all zero",
               bus.mem_rd, bus.mem_addr, bus.data_out, bus.valid, bus.rowend, bus.clrbuffer, busy, done);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_done: got done_pulses=%0d busy=%b expected 0 0", ndone, busy);
    end
  endtask

  task automatic test_reset_and_start();
    res = 1'b1; start = 1'b1;
    step();
    res = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.clrbuffer !== 1'b0) begin
      failures++;
      $display("FAIL res_start_same: got busy=%b clr=%b expected 0 0", busy, bus.clrbuffer);
    end
    step();
    checks++;
    if (busy !== 1'b0 || bus.clrbuffer !== 1'b0) begin
      failures++;
      $display("FAIL res_start_after: got busy=%b clr=%b expected 0 0", busy, bus.clrbuffer);
    end
  endtask

  task automatic test_start_while_busy();
    int nclr = 0;
    int ndone = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.clrbuffer) nclr++;
      if (done) ndone++;
      start = (c == 3 || c == 6 || c == 4 + NB) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    checks++;
    if (nclr != 1 || ndone != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_busy: got clr_pulses=%0d done_pulses=%0d busy=%b expected 1 1 0", nclr, ndone, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; start = 1'b0; bus.stall = 1'b0;
    test_reset();
    test_basic_frame();
    test_stall_hold();
    test_random_stall();
    test_reset_mid_stream();
    test_basic_frame();
    test_reset_and_start();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_frame_streamer.md
# conv_frame_streamer

Upstream feeder for the 3x3 line-buffered convolution stage. On a start pulse it reads one grayscale frame from a word-addressed pixel memory, packs NO_PARALLEL_UNITS pixels per beat, and drives the convolver's lane data, per-beat row-edge flags, buffer-clear pulse and valid. It honours the convolver's stall without dropping or duplicating beats, and optionally appends zero flush rows so the convolver's line buffers drain the last image row.

## Interface
- IM_LEN, 520: pixels per row; must be a multiple of NO_PARALLEL_UNITS
- IM_ROWS, 520: rows per frame
- ker, 3: kernel size; rowend width is ker-1
- NO_PARALLEL_UNITS, 4: pixels per beat (lanes)
- ADDR_W, 18: memory word-address width; must satisfy 2^ADDR_W >= IM_ROWS*IM_LEN/NO_PARALLEL_UNITS
- clk  in  1  the only clock, rising edge
- res  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request; ignored unless idle
- stall  in  1  downstream hold; the current beat must stay on the outputs
- mem_rd  out  1  memory read enable
- mem_addr  out  ADDR_W  word address, one word per beat, row-major
- mem_data  in  NO_PARALLEL_UNITS*8  read data, valid exactly 1 cycle after mem_rd; lane k is bits [8k+7:8k]
- data_out  out  NO_PARALLEL_UNITS*8  packed pixels, same lane order
- valid  out  1  data_out/rowend carry a beat
- rowend  out  ker-1  bit0 = beat is not the first beat of its row; bit1 = beat is not the last beat of its row
- clrbuffer  out  1  one-cycle pulse, clears the convolver before a frame
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- BPR = IM_LEN/NO_PARALLEL_UNITS beats per row. Counters: col (0..BPR-1) and row (0..IM_ROWS-1+FLUSH_ROWS). FLUSH_ROWS = ker/2 when the flush feature is enabled, otherwise 0.
- FSM states are IDLE, CLEAR, STREAM, FLUSH and FIN.
- IDLE moves to CLEAR on start.
- CLEAR lasts exactly one cycle with clrbuffer=1. It is not stallable. It always moves to STREAM.
- STREAM issues reads at mem_addr = row*BPR + col, incrementing linearly. A read is issued only when the 2-entry skid buffer has room for it after the in-flight read.
- STREAM moves to FLUSH (or to FIN when FLUSH_ROWS=0) once the last frame beat is issued.
- FLUSH emits FLUSH_ROWS*BPR beats with data_out=0, no reads, and the normal rowend pattern.
- FIN waits until the skid buffer is empty and the last beat is accepted, then pulses done and returns to IDLE.
- A beat is accepted on any cycle with valid=1 and stall=0. While stall=1, data_out, rowend and valid hold their values.
- rowend values: 2'b10 on col 0, 2'b01 on col BPR-1, 2'b11 otherwise. When BPR=1 it is 2'b00.
- Boundaries:
  - start while busy is ignored.
  - start and res in the same cycle: res wins.
  - res at any point forces IDLE, empties the skid buffer and discards the in-flight read; done is not pulsed.
  - Address never exceeds IM_ROWS*BPR-1.
  - Stall asserted in CLEAR takes effect from the first STREAM cycle.

## Timing
- Reset values: mem_rd=0, mem_addr=0, data_out=0, valid=0, rowend=0, clrbuffer=0, busy=0, done=0.
- Relative to the start cycle T:
  - clrbuffer=1 at T+1.
  - First mem_rd at T+2.
  - First valid beat at T+4: 1 cycle memory latency plus the registered skid/output stage.
- With stall held low, there is one beat per cycle, and done falls at T+4+IM_ROWS*BPR+FLUSH_ROWS*BPR.
- Stall-to-hold is 0 cycles: a beat is held in the same cycle stall rises. Resumption is 0 cycles: the held beat is accepted in the first stall=0 cycle, and the next beat follows in the next cycle with no bubble.

## Configuration
- CONV_STREAM_FLUSH_EN
  - Defined: FLUSH state present, with ker/2 zero rows appended after the frame.
  - Undefined: FLUSH is removed, STREAM goes directly to FIN, and the beat count is exactly IM_ROWS*BPR.

## Structure
- Shared package conv_pkg:
  - state enum (IDLE, CLEAR, STREAM, FLUSH, FIN)
  - rowend constants ROWEND_FIRST=2'b10, ROWEND_LAST=2'b01, ROWEND_MID=2'b11
  - lane width constant PIX_W=8
- Sub-module stream_skid2: a 2-entry buffer carrying {data, rowend}. It absorbs the in-flight memory word when stall rises, and it provides the room signal that gates mem_rd.

## Test plan
All scenarios use IM_LEN=8, IM_ROWS=3, NO_PARALLEL_UNITS=4 (BPR=2), and memory word n = {4{8'(n)}}.
- Basic frame, no stall, flush off:
  - clrbuffer at T+1.
  - Beats n=0..5 at T+4..T+9, rowend sequence 10,01 per row.
  - done at T+10.
- Flush on:
  - Same as basic, followed by 2 zero beats with rowend 10,01.
  - done at T+12.
- Stall held 3 cycles starting on beat 2: beat 2 is held for 3 cycles, then beats 3,4,5 are delivered without gap, with no duplicates or drops and mem_addr ≤5.
- Random stall (50%) over the frame: accepted beat sequence equals 0..5 exactly, and rowend is correct per beat.
- res asserted mid-STREAM: all outputs return to reset values the next cycle and there is no done. A new start reproduces the basic-frame timing.
- start pulsed while busy: ignored, with a single done and a single clrbuffer per frame.
